// File: rtl/one_by_three_demultiplexer_pkg.sv
// Shared types and helpers for the 1-to-3 demultiplexer.
//   route_t       : output selector (A, B, C)
//   slot_state_t  : one-entry output slot occupancy
//   decode_route  : {sel1,sel2} -> route, same encoding as the 3-input mux
//   next_route    : round-robin successor A -> B -> C -> A
package one_by_three_demultiplexer_pkg;

  localparam int unsigned ROUTE_W = 2;

  typedef enum logic [ROUTE_W-1:0] {
    ROUTE_A = 2'd0,
    ROUTE_B = 2'd1,
    ROUTE_C = 2'd2
  } route_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // 10 is an alias of 11; both steer to C.
  function automatic route_t decode_route(input logic sel1, input logic sel2);
    route_t r;
    case ({sel1, sel2})
      2'b00:   r = ROUTE_A;
      2'b01:   r = ROUTE_B;
      default: r = ROUTE_C;
    endcase
    return r;
  endfunction

  function automatic route_t next_route(input route_t r);
    route_t n;
    case (r)
      ROUTE_A: n = ROUTE_B;
      ROUTE_B: n = ROUTE_C;
      default: n = ROUTE_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/one_by_three_demultiplexer_out_slot.sv
// One-entry output buffer with valid/ready handshake.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : write data into the slot this cycle (only when space_c)
//   data       : word to load
//   drain      : consumer ready; empties a FULL slot unless reloaded
//   valid      : slot holds a word (registered state)
//   data_out   : registered word, held while valid && !drain
//   space_c    : slot can accept a word this cycle (EMPTY, or FULL and draining)
module demux_out_slot
  import one_by_three_demultiplexer_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic             space_c
);

  slot_state_t state, state_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next state: load wins over drain so a simultaneous drain+load stays FULL.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (drain && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Data register; only written on load so an EMPTY slot keeps its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_out <= '0;
    else if (load) data_out <= data;
  end

  assign valid   = (state == FULL);
  assign space_c = (state == EMPTY) || drain;

endmodule

// File: rtl/one_by_three_demultiplexer.sv
// Registered 1-to-3 demultiplexer with per-output one-entry buffers.
// Steers the input stream to A, B or C; a stalled consumer only blocks words
// routed to it.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   in, in_valid, in_ready   : input stream (in_ready is combinational)
//   sel1, sel2               : route select {sel1,sel2}: 00->A, 01->B, 1x->C
//   A/B/C, *_valid, *_ready  : output streams
// Build option DEMUX_RR_EN: ignore sel1/sel2 and route round-robin A->B->C,
// advancing on each accepted word.
module one_by_three_demultiplexer
  import one_by_three_demultiplexer_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel1,
  input  logic             sel2,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             A_valid,
  output logic             B_valid,
  output logic             C_valid,
  input  logic             A_ready,
  input  logic             B_ready,
  input  logic             C_ready
);

  localparam int unsigned N_OUT = 3;

  route_t             route_c;
  logic               accept_c;
  logic [N_OUT-1:0]   space_c;
  logic [N_OUT-1:0]   load_c;

`ifdef DEMUX_RR_EN
  route_t rr_q;
  logic   unused_sel;

  assign unused_sel = sel1 ^ sel2;

  // Round-robin pointer, advances only on accepted words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rr_q <= ROUTE_A;
    else if (accept_c) rr_q <= next_route(rr_q);
  end

  assign route_c = rr_q;
`else
  assign route_c = decode_route(sel1, sel2);
`endif

  // Ready reflects only the selected slot, independent of in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (route_c)
      ROUTE_A: in_ready = space_c[0];
      ROUTE_B: in_ready = space_c[1];
      default: in_ready = space_c[2];
    endcase
  end

  assign accept_c  = in_valid && in_ready;
  assign load_c[0] = accept_c && (route_c == ROUTE_A);
  assign load_c[1] = accept_c && (route_c == ROUTE_B);
  assign load_c[2] = accept_c && (route_c == ROUTE_C);

  demux_out_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c[0]),
    .data     (in),
    .drain    (A_ready),
    .valid    (A_valid),
    .data_out (A),
    .space_c  (space_c[0])
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c[1]),
    .data     (in),
    .drain    (B_ready),
    .valid    (B_valid),
    .data_out (B),
    .space_c  (space_c[1])
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot_c (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c[2]),
    .data     (in),
    .drain    (C_ready),
    .valid    (C_valid),
    .data_out (C),
    .space_c  (space_c[2])
  );

endmodule

// File: tb/tb_one_by_three_demultiplexer.sv
// Bench for one_by_three_demultiplexer: directed vector table plus a
// queue-based scoreboard that tracks every word from accept to drain.
module tb_one_by_three_demultiplexer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         in_valid;
  logic         in_ready;
  logic         sel1, sel2;
  logic [W-1:0] A, B, C;
  logic         A_valid, B_valid, C_valid;
  logic         A_ready, B_ready, C_ready;

  int total = 0;
  int bad   = 0;

  one_by_three_demultiplexer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel1     (sel1),
    .sel2     (sel2),
    .A        (A),
    .B        (B),
    .C        (C),
    .A_valid  (A_valid),
    .B_valid  (B_valid),
    .C_valid  (C_valid),
    .A_ready  (A_ready),
    .B_ready  (B_ready),
    .C_ready  (C_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // rdy / exp_v bit order: [2]=A, [1]=B, [0]=C
  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [2:0] r);
    in_valid = v;
    sel1     = s[1];
    sel2     = s[0];
    din      = d;
    A_ready  = r[2];
    B_ready  = r[1];
    C_ready  = r[0];
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] sbq [3][$];
  int           rr_m = 0;

  always @(negedge clk) begin
    logic [W-1:0] dv [3];
    logic         vv [3];
    logic         rv [3];
    logic [W-1:0] e;
    logic         exp_ir;
    int           r;
    dv = '{A, B, C};
    vv = '{A_valid, B_valid, C_valid};
    rv = '{A_ready, B_ready, C_ready};
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) sbq[k].delete();
      rr_m = 0;
    end else begin
`ifdef DEMUX_RR_EN
      r = rr_m;
`else
      r = (!sel1 && !sel2) ? 0 : (!sel1 ? 1 : 2);
`endif
      exp_ir = (sbq[r].size() == 0) || rv[r];
      chk("sb_in_ready", 32'(in_ready), 32'(exp_ir));
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("sb_valid_%0d", k), 32'(vv[k]), 32'(sbq[k].size() != 0));
        if (vv[k] && rv[k] && sbq[k].size() != 0) begin
          e = sbq[k].pop_front();
          chk($sformatf("sb_data_%0d", k), 32'(dv[k]), 32'(e));
        end
      end
      if (in_valid && in_ready) begin
        sbq[r].push_back(din);
`ifdef DEMUX_RR_EN
        rr_m = (rr_m + 1) % 3;
`endif
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic         vld;
    logic [1:0]   sel;
    logic [W-1:0] din;
    logic [2:0]   rdy;
    logic         exp_ir;
    logic [2:0]   exp_v;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    logic [W-1:0] exp_c;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1'b1, 2'b01, 8'h11, 3'b000, 1'b1, 3'b000, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 2'b01, 8'h22, 3'b000, 1'b0, 3'b010, 8'h00, 8'h11, 8'h00};
    vecs[2]  = '{1'b1, 2'b01, 8'h22, 3'b010, 1'b1, 3'b010, 8'h00, 8'h11, 8'h00};
    vecs[3]  = '{1'b1, 2'b00, 8'h33, 3'b000, 1'b1, 3'b010, 8'h00, 8'h22, 8'h00};
    vecs[4]  = '{1'b0, 2'b00, 8'h00, 3'b000, 1'b0, 3'b110, 8'h33, 8'h22, 8'h00};
    vecs[5]  = '{1'b1, 2'b10, 8'h44, 3'b110, 1'b1, 3'b110, 8'h33, 8'h22, 8'h00};
    vecs[6]  = '{1'b1, 2'b11, 8'h55, 3'b001, 1'b1, 3'b001, 8'h33, 8'h22, 8'h44};
    vecs[7]  = '{1'b1, 2'b10, 8'h66, 3'b001, 1'b1, 3'b001, 8'h33, 8'h22, 8'h55};
    vecs[8]  = '{1'b0, 2'b00, 8'h00, 3'b000, 1'b1, 3'b001, 8'h33, 8'h22, 8'h66};
    vecs[9]  = '{1'b0, 2'b10, 8'h00, 3'b001, 1'b1, 3'b001, 8'h33, 8'h22, 8'h66};
    vecs[10] = '{1'b1, 2'b00, 8'h77, 3'b000, 1'b1, 3'b000, 8'h33, 8'h22, 8'h66};
    vecs[11] = '{1'b1, 2'b01, 8'h88, 3'b000, 1'b1, 3'b100, 8'h77, 8'h22, 8'h66};
    vecs[12] = '{1'b1, 2'b10, 8'h99, 3'b000, 1'b1, 3'b110, 8'h77, 8'h88, 8'h66};
    vecs[13] = '{1'b1, 2'b00, 8'haa, 3'b000, 1'b0, 3'b111, 8'h77, 8'h88, 8'h99};

    // Reset with all consumers stalled.
    rst_n = 1'b0;
    drive(1'b0, 2'b00, '0, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'({A_valid, B_valid, C_valid}), 32'd0);
    chk("rst_data", 32'({A, B, C}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifndef DEMUX_RR_EN
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].vld, vecs[i].sel, vecs[i].din, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      chk($sformatf("v%0d_valid", i), 32'({A_valid, B_valid, C_valid}), 32'(vecs[i].exp_v));
      chk($sformatf("v%0d_A", i), 32'(A), 32'(vecs[i].exp_a));
      chk($sformatf("v%0d_B", i), 32'(B), 32'(vecs[i].exp_b));
      chk($sformatf("v%0d_C", i), 32'(C), 32'(vecs[i].exp_c));
    end
`else
    // Round-robin fill with sel held at B; words land on A, B, C in turn.
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 2'b01, 8'(i), 3'b000);
    end
    @(negedge clk);
    chk("rr_valid", 32'({A_valid, B_valid, C_valid}), 32'b111);
    chk("rr_data", 32'({A, B, C}), 32'h010203);
    chk("rr_in_ready", 32'(in_ready), 32'd0);
`endif

    // Reset mid-operation with every slot FULL.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'({A_valid, B_valid, C_valid}), 32'd0);
    chk("midrst_data", 32'({A, B, C}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, '0, 3'b000);
    rst_n = 1'b1;

`ifdef DEMUX_RR_EN
    // Pointer restarts at A regardless of sel.
    @(posedge clk); #1;
    drive(1'b1, 2'b10, 8'h5a, 3'b000);
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 8'h00, 3'b000);
    @(negedge clk);
    chk("rr_after_rst", 32'({A_valid, B_valid, C_valid}), 32'b100);
    chk("rr_after_rst_A", 32'(A), 32'h5a);
`endif

    // Back-to-back stream with consumers always ready: no bubbles.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 2'b01, 8'(8'hc0 + i), 3'b111);
      @(negedge clk);
      chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
    end

    // Random traffic, all checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
            {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
    end

    @(posedge clk); #1;
    drive(1'b0, 2'b00, '0, 3'b111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drained_valid", 32'({A_valid, B_valid, C_valid}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/one_by_three_demultiplexer.md
# one_by_three_demultiplexer

Registered 1-to-3 demultiplexer: the receiving-side counterpart of the three-input multiplexer. It steers a single input stream to one of three outputs, A, B or C. The select pins use the same sel1/sel2 encoding as the multiplexer, so a mux/demux pair driven by identical selects forms a transparent link. Each output has a one-entry buffer with a valid/ready handshake, so a stalled consumer back-pressures only the traffic routed to it.

## Interface
- WIDTH, 1, data width of input and each output
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  WIDTH  input data
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- sel1  input  1  route select, high bit
- sel2  input  1  route select, low bit
- A, B, C  output  WIDTH each  registered output data
- A_valid, B_valid, C_valid  output  1 each  output slot holds a word
- A_ready, B_ready, C_ready  input  1 each  consumer takes the word this cycle

## Operation
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Route decode, sampled with in_valid, same encoding as the mux:
  - {sel1,sel2}=00 → A
  - 01 → B
  - 10 and 11 → C (10 is an alias of 11)
- Output slots: each of A, B and C is a one-entry slot with states EMPTY and FULL.
- Accept rule: input is accepted when in_valid && in_ready.
  - in_ready = (selected slot EMPTY) || (selected slot FULL && its _ready high).
  - in_ready is combinational from sel1, sel2, slot state and the selected _ready. It does not depend on in_valid.
- Slot transitions:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on _ready with no accept to that slot.
  - FULL → FULL with new data on simultaneous drain and accept.
- Unselected slots:
  - Never load.
  - Drain independently whenever their _ready is high.
- Data hold: output data is held stable while _valid is high and _ready is low.
- Ignored inputs:
  - _ready on an EMPTY slot has no effect.
  - Output data of an EMPTY slot is don't-care and holds its last value.
- Select changes: sel1/sel2 may change every cycle. Only the value sampled at the accepting edge matters.

## Timing
- Reset values: all _valid = 0 and A/B/C = 0. in_ready = 1 after reset, since all slots are EMPTY.
- Latency: the word accepted at edge N is visible on the selected output with _valid = 1 after edge N.
- Throughput: one word per cycle to a single output when its consumer holds _ready high. There are no bubbles.
- Reset mid-operation: all buffered words are discarded, every slot returns to EMPTY, and the round-robin pointer (if compiled) returns to A.
- Simultaneous events:
  - Drain of slot X and accept into slot Y≠X in the same cycle: both take effect.
  - Drain and accept on the same slot in the same cycle: the slot stays FULL with the new word.

## Configuration
- Macro: DEMUX_RR_EN.
- Defined:
  - sel1/sel2 are ignored.
  - Routing comes from an internal 2-bit pointer, A→B→C→A.
  - The pointer advances only on an accepted word and wraps from C back to A.
  - in_ready uses the pointer's slot.
- Undefined: no pointer is built and routing follows sel1/sel2 as above.

## Structure
- Package one_by_three_demultiplexer_pkg holds:
  - the route typedef, 2-bit: ROUTE_A=0, ROUTE_B=1, ROUTE_C=2
  - the decode function mapping {sel1,sel2} to route
  - the slot-state typedef (EMPTY, FULL)
- Sub-module demux_out_slot is the one-entry buffer with load, data, drain, valid and data-out. It is instantiated three times.

## Test plan
- Reset with all _ready=0 → all _valid=0, outputs 0, in_ready=1.
- sel=01, in=1 accepted, B_ready=0 → B=1, B_valid=1 the next cycle. A second word to sel=01 gives in_ready=0 until B_ready=1.
- B stalled and FULL, sel=00, in=1 → accepted into A. A_valid=1 while B stays held.
- sel=10 and sel=11, in=1 each with C_ready=1 → both words appear on C back-to-back.
- C FULL with C_ready=1 and a new accept to C in the same cycle → C updates to the new word and C_valid remains 1.
- rst_n pulsed low while A/B/C are FULL → all _valid=0 immediately. With DEMUX_RR_EN, the next accepted word goes to A, then B, then C, then A.
